// File: rtl/mem_2p_sync.sv
// rtl/mem_2p_sync.sv - two-port word/byte-lane RAM: read-only fetch port I, load/store port D
// Optional MEM_FWD_EN: same-cycle same-word store data is forwarded to the fetch port.
module mem_2p_sync #(
    parameter int DEPTH_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_wdata,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err
);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int IW    = AW - 2;

    logic [31:0]   mem [WORDS];
    logic [IW-1:0] i_idx, d_idx;
    logic [1:0]    lane;
    logic          i_fault, d_fault, d_wr;
    logic [3:0]    strb;
    logic [31:0]   wrep, d_word, d_load, i_word;
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;

    assign i_idx = i_addr[AW-1:2];
    assign d_idx = d_addr[AW-1:2];
    assign lane  = d_addr[1:0];

    assign i_fault = (i_addr >= 32'(DEPTH_BYTES)) || (i_addr[1:0] != 2'b00);

    always_comb begin
        d_fault = (d_addr >= 32'(DEPTH_BYTES));
        strb    = 4'b0000;
        wrep    = d_wdata;
        case (d_size)
            2'b00: begin
                strb[lane] = 1'b1;
                wrep       = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                if (lane[0]) d_fault = 1'b1;
                strb = lane[1] ? 4'b1100 : 4'b0011;
                wrep = {2{d_wdata[15:0]}};
            end
            2'b10: begin
                if (lane != 2'b00) d_fault = 1'b1;
                strb = 4'b1111;
            end
            default: d_fault = 1'b1;
        endcase
    end

    // Requests presented while rst is high are dropped, so reset also gates the write.
    assign d_wr = !rst && d_req && d_we && !d_fault;

    always_ff @(posedge clk) begin
        if (d_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem[d_idx][8*b +: 8] <= wrep[8*b +: 8];
            end
        end
    end

    assign d_word = mem[d_idx];
    assign ld_b   = d_word[{lane, 3'b000} +: 8];
    assign ld_h   = d_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        case (d_size)
            2'b00:   d_load = {{24{ld_b[7] & ~d_unsigned}}, ld_b};
            2'b01:   d_load = {{16{ld_h[15] & ~d_unsigned}}, ld_h};
            default: d_load = d_word;
        endcase
    end

`ifdef MEM_FWD_EN
    always_comb begin
        i_word = mem[i_idx];
        if (d_wr && (d_idx == i_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) i_word[8*b +: 8] = wrep[8*b +: 8];
            end
        end
    end
`else
    // The nonblocking array write lands after this read, giving read-before-write.
    assign i_word = mem[i_idx];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            i_rvalid <= 1'b0;
            i_rdata  <= 32'h0;
            i_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= 32'h0;
            d_err    <= 1'b0;
        end else begin
            i_rvalid <= i_req;
            if (i_req) begin
                i_err   <= i_fault;
                i_rdata <= i_fault ? 32'h0 : i_word;
            end
            d_rvalid <= d_req;
            if (d_req) begin
                d_err   <= d_fault;
                d_rdata <= (d_we || d_fault) ? 32'h0 : d_load;
            end
        end
    end
endmodule

// File: doc/mem_2p_sync.md
Name: mem_2p_sync

Overview:
- Parametrised successor to the two-port byte RAM. Port I is a read-only instruction-fetch port; port D is a data load/store port.
- Storage is word-organised with byte lanes. Reads are registered with one-cycle latency. Writes use byte strobes derived from RV32 access size.
- Loads return sign- or zero-extended results. Misaligned and out-of-range accesses are flagged, not executed.
- Sits between the core's IF/MEM stages and on-chip storage.

Parameters:
- DEPTH_BYTES, 4096, total capacity in bytes; power of two, at least 8.
- WORDS, DEPTH_BYTES/4, derived storage depth in 32-bit words; not overridable.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- i_req  in  1  fetch request this cycle.
- i_addr  in  32  fetch byte address.
- i_rvalid  out  1  fetch response valid; one cycle after i_req.
- i_rdata  out  32  fetched word.
- i_err  out  1  fetch fault; valid with i_rvalid.
- d_req  in  1  data request this cycle.
- d_we  in  1  1 = store, 0 = load; qualified by d_req.
- d_addr  in  32  data byte address.
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- d_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- d_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- d_rvalid  out  1  data response valid; one cycle after d_req, for loads and stores.
- d_rdata  out  32  load result; 0 for stores and faults.
- d_err  out  1  data fault; valid with d_rvalid.

Behaviour:
- Clock and reset: single clock domain. rst is synchronous and active-high.
- Reset values: i_rvalid=0, i_rdata=0, i_err=0, d_rvalid=0, d_rdata=0, d_err=0. Storage is not cleared.
- Requests during reset: a request presented in a cycle with rst=1 is dropped. No write occurs and no response follows.
- Latency and handshake: a request accepted at edge N gives rvalid=1 after edge N+1, for exactly one cycle.
  - There is no backpressure. Both ports accept one request per cycle, back-to-back.
  - With no request, rvalid=0. rdata and err hold their last values.
- Word index: addr[log2(DEPTH_BYTES)-1:2]. Lane = addr[1:0].
- Fault conditions (err=1, rdata=0, store suppressed):
  - addr >= DEPTH_BYTES on either port.
  - Port I: i_addr[1:0] != 0.
  - Port D: d_size=11; half with addr[0]=1; word with addr[1:0]!=0.
- Store strobes:
  - byte: lane addr[1:0].
  - half: lanes {addr[1],0} and {addr[1],1}.
  - word: all four lanes.
  - d_wdata is replicated into the lane positions. Unstrobed bytes are unchanged.
- Little-endian: the byte at address A sits in lane A[1:0]. Lane 0 = bits [7:0].
- Load extraction:
  - Select the byte or half at the lane and shift it to bit 0.
  - Extend to 32 bits from bit 7 (byte) or bit 15 (half), sign or zero per d_unsigned.
  - Word loads ignore d_unsigned.
- Port D store response: d_rvalid=1, d_rdata=0, and d_err reflects the fault check.
- Collision (port I reads the same word port D stores to in the same cycle): port I returns old contents (read-before-write) unless MEM_FWD_EN is defined.
- Port D load followed by store: one op per cycle, so a load at N+1 sees a store at N.

Optional Feature:
- Macro: MEM_FWD_EN.
- Defined: on a same-cycle, same-word collision, i_rdata returns the word with the strobed lanes of the store merged in (write-first). Store faults suppress the merge.
- Undefined: read-before-write; i_rdata returns the pre-store word.

Test Plan:
- Reset: assert rst 2 cycles with d_req=1, d_we=1 -> all outputs 0, no rvalid; a later word load from that address is unaffected by the store.
- Word store 0xDEADBEEF at 0x10, then word load 0x10 next cycle -> d_rvalid at N+1 of the load, d_rdata=0xDEADBEEF. i_req at 0x10 -> i_rdata=0xDEADBEEF.
- Byte/half access:
  - Store byte 0x7F at 0x13 -> word 0x10 reads 0x7FADBEEF.
  - Load byte signed at 0x11 -> 0xFFFFFFBE; unsigned -> 0x000000BE.
  - Load half signed at 0x12 -> 0x00007FAD.
- Faults:
  - Half load at 0x21 -> d_err=1, d_rdata=0.
  - Word store at 0x22 -> d_err=1, memory unchanged.
  - Fetch at DEPTH_BYTES -> i_err=1.
  - d_size=11 -> d_err=1.
- Collision: word 0x40=0x11111111; same cycle, store word 0x22222222 at 0x40 and fetch 0x40 -> i_rdata=0x11111111 without MEM_FWD_EN, 0x22222222 with it. Next fetch -> 0x22222222 in both builds.
- Back-to-back: 8 consecutive fetches at 0x0..0x1C interleaved with stores -> one i_rvalid per request, in order, each exactly one cycle late.
